// File: rtl/squeeze_out_ctrl.sv
// Squeeze-phase output sequencer: walks each rate block through the 1344-to-64 PISO
// one word at a time and requests another permutation when a block runs dry.
module squeeze_out_ctrl #(
    parameter int WORDS_PER_BLOCK = 21,
    parameter int LEN_W           = 16,
    parameter int IDX_W           = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] total_words,
    input  logic             abort,
    input  logic             blk_valid,
    output logic             blk_ack,
    output logic             perm_req,
    output logic             load_en,
    output logic             shift_en,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             last_word,
    output logic [IDX_W-1:0] word_idx,
    output logic [LEN_W-1:0] words_left,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_BLK = 3'd1,
        S_LOAD     = 3'd2,
        S_STREAM   = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);
    localparam logic [LEN_W-1:0] ONE_WORD = LEN_W'(1);

    state_t state;
    logic   handshake;
    logic   block_end;
    logic   final_word;

    // Word handshake: word_valid is high for the whole STREAM state and the word
    // on the PISO output stays put until accepted; a transfer happens in any cycle
    // with word_valid & word_ready, and that same cycle shifts the PISO.
    assign word_valid = (state == S_STREAM);
    assign handshake  = word_valid & word_ready & ~abort;
    assign block_end  = (word_idx == LAST_IDX);
    assign final_word = (words_left == ONE_WORD);

    assign shift_en  = handshake;
    assign last_word = word_valid & final_word;
    assign load_en   = (state == S_LOAD) & ~abort;
    assign blk_ack   = (state == S_LOAD) & ~abort;
    // Only a non-final block boundary needs another permutation.
    assign perm_req  = handshake & block_end & ~final_word;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            words_left <= '0;
            word_idx   <= '0;
        end else if (abort) begin
            state      <= S_IDLE;
            words_left <= '0;
            word_idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (total_words != '0) begin
                            words_left <= total_words;
                            word_idx   <= '0;
                            state      <= S_WAIT_BLK;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_WAIT_BLK: begin
                    if (blk_valid) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    word_idx <= '0;
                    state    <= S_STREAM;
                end
                S_STREAM: begin
                    if (handshake) begin
                        words_left <= words_left - ONE_WORD;
                        if (final_word) begin
                            state <= S_DONE;
                        end else if (block_end) begin
                            word_idx <= '0;
                            state    <= S_WAIT_BLK;
                        end else begin
                            word_idx <= word_idx + IDX_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_idx_in_block: assert property (@(posedge clk) disable iff (!rst_n)
        word_idx <= LAST_IDX);
    a_shift_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
        shift_en |-> word_valid);
    a_perm_on_transfer: assert property (@(posedge clk) disable iff (!rst_n)
        perm_req |-> shift_en);
`endif

endmodule
